ex_muldiv: RTL

Iterative integer multiply/divide unit in the execute stage. It sits directly downstream of the ID/EX pipeline latch and takes that latch's operand outputs (rdat1/rdat2) and decoded mult/div op. It computes MULT, MULTU, DIV and DIVU into architectural HI/LO registers over multiple cycles. While it works, it drives a stall request back to the hazard logic, so that MFHI/MFLO and any new mult/div wait until the result is committed.

---
 rtl/ex_muldiv_pkg.sv | 31 +++
 rtl/ex_muldiv_if.sv | 30 +++
 rtl/ex_muldiv_signfix.sv | 26 ++
 rtl/ex_muldiv.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
//   DATA_W     : operand and HI/LO width (only 32 is supported)
//   MD_ITER    : iterations per multiply/divide
//   md_op_t    : decoded mult/div operation from ID/EX
//   md_state_t : sequencer states
//   abs_val    : magnitude of an operand, or the raw value for unsigned ops
package ex_muldiv_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_MULT,
        MD_MULTU,
        MD_DIV,
        MD_DIVU
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIXUP
    } md_state_t;

    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                 input logic              is_signed);
        return (is_signed && v[DATA_W-1]) ? (~v + DATA_W'(1)) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Bundle between the ID/EX latch / hazard logic and the multiply/divide unit.
//   master : pipeline side (drives start, md_op, opa, opb, flush, hilo_we, hilo_sel, wdat)
//   slave  : ex_muldiv (drives hi, lo, busy, done)
interface ex_muldiv_if;
    import ex_muldiv_pkg::*;

    logic              start;
    md_op_t            md_op;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic              flush;
    logic              hilo_we;
    logic              hilo_sel;
    logic [DATA_W-1:0] wdat;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              busy;
    logic              done;

    modport master (
        output start, md_op, opa, opb, flush, hilo_we, hilo_sel, wdat,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, md_op, opa, opb, flush, hilo_we, hilo_sel, wdat,
        output hi, lo, busy, done
    );

endinterface

// File: rtl/ex_muldiv_signfix.sv
// Combinational sign correction applied in FIXUP.
//   prod, quo, rem      : unsigned magnitudes from the iterative datapath
//   neg_res             : operand signs differed (negate product / quotient)
//   neg_rem             : dividend was negative (negate remainder)
//   prod_fix, quo_fix,
//   rem_fix             : signed results ready for HI/LO
module ex_muldiv_signfix
    import ex_muldiv_pkg::*;
(
    input  logic [2*DATA_W-1:0] prod,
    input  logic [DATA_W-1:0]   quo,
    input  logic [DATA_W-1:0]   rem,
    input  logic                neg_res,
    input  logic                neg_rem,
    output logic [2*DATA_W-1:0] prod_fix,
    output logic [DATA_W-1:0]   quo_fix,
    output logic [DATA_W-1:0]   rem_fix
);

    always_comb begin
        prod_fix = neg_res ? -prod : prod;
        quo_fix  = neg_res ? -quo  : quo;
        rem_fix  = neg_rem ? -rem  : rem;
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit in the execute stage, writing HI/LO.
//   CLK   : clock, rising edge
//   RST   : synchronous active-high reset
//   md    : ex_muldiv_if.slave
//           start/md_op/opa/opb launch an operation, flush aborts it,
//           hilo_we/hilo_sel/wdat implement MTHI/MTLO,
//           hi/lo are the architectural registers, busy is the stall request,
//           done pulses for one cycle once HI/LO hold a new result.
// Build option: MULDIV_EARLY_OUT_EN ends MUL as soon as the remaining
// multiplier bits are all zero.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    ex_muldiv_if.slave  md
);

    localparam logic [5:0] LastIter = 6'(MD_ITER - 1);

    md_state_t             state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [2*DATA_W-1:0]   prod_q, prod_d;      // multiply accumulator
    logic [2*DATA_W-1:0]   mcand_q, mcand_d;    // multiplicand, shifted left each step
    logic [DATA_W-1:0]     mplier_q, mplier_d;  // multiplier (shifted right) or divisor
    logic [DATA_W:0]       rem_q, rem_d;        // partial remainder
    logic [DATA_W-1:0]     quo_q, quo_d;        // dividend shifting out, quotient shifting in
    logic                  is_div_q, is_div_d;
    logic                  div0_q, div0_d;
    logic                  neg_res_q, neg_res_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [DATA_W-1:0]     hi_q, hi_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic                  done_q, done_d;

    logic                  op_signed;
    logic                  op_is_div;
    logic [DATA_W-1:0]     abs_a;
    logic [DATA_W-1:0]     abs_b;
    logic [DATA_W+1:0]     rem_sh;
    logic [DATA_W+1:0]     rem_diff;
    logic [2*DATA_W-1:0]   prod_fix;
    logic [DATA_W-1:0]     quo_fix;
    logic [DATA_W-1:0]     rem_fix;

    assign op_signed = (md.md_op == MD_MULT) || (md.md_op == MD_DIV);
    assign op_is_div = (md.md_op == MD_DIV)  || (md.md_op == MD_DIVU);
    assign abs_a     = abs_val(md.opa, op_signed);
    assign abs_b     = abs_val(md.opb, op_signed);

    // One extra headroom bit so the borrow of the trial subtraction is the MSB.
    assign rem_sh   = {rem_q, quo_q[DATA_W-1]};
    assign rem_diff = rem_sh - {2'b00, mplier_q};

    ex_muldiv_signfix u_signfix (
        .prod     (prod_q),
        .quo      (quo_q),
        .rem      (rem_q[DATA_W-1:0]),
        .neg_res  (neg_res_q),
        .neg_rem  (neg_rem_q),
        .prod_fix (prod_fix),
        .quo_fix  (quo_fix),
        .rem_fix  (rem_fix)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        is_div_d  = is_div_q;
        div0_d    = div0_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // MTHI/MTLO first; a launch in the same cycle overwrites later.
                if (md.hilo_we) begin
                    if (md.hilo_sel) hi_d = md.wdat;
                    else             lo_d = md.wdat;
                end
                if (md.start && !md.flush) begin
                    cnt_d     = '0;
                    mplier_d  = abs_b;
                    neg_res_d = op_signed && (md.opa[DATA_W-1] ^ md.opb[DATA_W-1]);
                    if (op_is_div) begin
                        is_div_d  = 1'b1;
                        div0_d    = (md.opb == '0);
                        neg_rem_d = op_signed && md.opa[DATA_W-1];
                        rem_d     = '0;
                        // Divide by zero reports the raw dividend in HI.
                        quo_d     = (md.opb == '0) ? md.opa : abs_a;
                        state_d   = DIV;
                    end else begin
                        is_div_d  = 1'b0;
                        div0_d    = 1'b0;
                        neg_rem_d = 1'b0;
                        prod_d    = '0;
                        mcand_d   = {{DATA_W{1'b0}}, abs_a};
                        state_d   = MUL;
                    end
                end
            end

            MUL: begin
                if (mplier_q[0]) prod_d = prod_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 6'd1;
`ifdef MULDIV_EARLY_OUT_EN
                if ((cnt_q == LastIter) || (mplier_d == '0)) state_d = FIXUP;
`else
                if (cnt_q == LastIter) state_d = FIXUP;
`endif
            end

            DIV: begin
                if (div0_q) begin
                    state_d = FIXUP;
                end else begin
                    if (!rem_diff[DATA_W+1]) begin
                        rem_d = rem_diff[DATA_W:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[DATA_W:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LastIter) state_d = FIXUP;
                end
            end

            FIXUP: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (div0_q) begin
                    hi_d = quo_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end

            default: state_d = IDLE;
        endcase

        // Abort discards the operation, including a FIXUP write this cycle.
        if (md.flush && (state_q != IDLE)) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prod_q    <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            is_div_q  <= is_div_d;
            div0_q    <= div0_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign md.busy = !RST && ((md.start && !md.flush && (state_q == IDLE)) || (state_q != IDLE));
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
    assign md.done = done_q;

endmodule
